// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: start/busy/done handshake and HI/LO result bus of the multiply/divide unit
// master (control unit): drives start_mult, start_div, a, b; reads hi, lo, busy, done, div_zero
// slave (mult_div_unit): the reverse directions
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;
    modport master (output start_mult, start_div, a, b, input hi, lo, busy, done, div_zero);
    modport slave (input start_mult, start_div, a, b, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed Booth multiply / restoring divide with HI/LO registers
// clk: rising-edge clock; reset: synchronous active-low reset
// bus (slave): start_mult/start_div requests with operands a/b; hi/lo results; busy, done, div_zero status
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(ITER) + 1;
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q, r_m, r_hi, r_lo;
    logic             r_q1, r_div, r_negq, r_negr, r_dz;
    logic [CW-1:0]    r_cnt;
    logic             w_busy, w_last, w_start;
    logic [WIDTH:0]   w_mext, w_bsum, w_shift, w_trial;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    assign w_busy  = r_state == MUL || r_state == DIV || r_state == FIX;
    assign w_last  = r_cnt == CW'(ITER - 1);
    assign w_start = bus.start_mult || bus.start_div;
    assign w_abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign w_abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;
    // Booth accumulator is one bit wider so that subtracting the most negative multiplicand cannot overflow
    assign w_mext  = {r_m[WIDTH-1], r_m};
    assign w_bsum  = ({r_q[0], r_q1} == 2'b01) ? r_acc + w_mext :
                     ({r_q[0], r_q1} == 2'b10) ? r_acc - w_mext : r_acc;
    // Restoring step: a set top bit of the trial difference means it went negative
    assign w_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_m};
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.busy     = w_busy;
    assign bus.done     = r_state == DONE;
    assign bus.div_zero = r_state == DONE && r_dz;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = bus.start_mult ? MUL : bus.start_div ? DIV : IDLE;
            MUL:        w_next = w_last ? FIX : MUL;
            DIV:        w_next = (r_m == '0) ? DONE : w_last ? FIX : DIV;
            FIX:        w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc  <= '0;
            r_q    <= '0;
            r_m    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_q1   <= 1'b0;
            r_div  <= 1'b0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
            r_dz   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: if (w_start) begin
                    r_acc  <= '0;
                    r_q1   <= 1'b0;
                    r_cnt  <= '0;
                    r_dz   <= 1'b0;
                    r_div  <= !bus.start_mult;
                    r_q    <= bus.start_mult ? bus.a : w_abs_a;
                    r_m    <= bus.start_mult ? bus.b : w_abs_b;
                    r_negq <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    r_negr <= bus.a[WIDTH-1];
                end
                MUL: begin
                    r_acc <= {w_bsum[WIDTH], w_bsum[WIDTH:1]};
                    r_q   <= {w_bsum[0], r_q[WIDTH-1:1]};
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt + CW'(1);
                end
                DIV: if (r_m == '0) r_dz <= 1'b1;
                else begin
                    r_acc <= w_trial[WIDTH] ? w_shift : w_trial;
                    r_q   <= {r_q[WIDTH-2:0], !w_trial[WIDTH]};
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: begin
                    r_hi <= (r_div && r_negr) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                    r_lo <= (r_div && r_negq) ? -r_q : r_q;
                end
                default: ;
            endcase
        end
    end
endmodule
